piso_tx: RTL and testbench
==========================

Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter: captures a 16-bit word and shifts it out one bit per clock, LSB first.
- SVALID qualifies each serial bit, so a 16-bit serial-in shift register (serial bit entering at bit 15, shifting toward bit 0) clock-enabled by SVALID holds the original word on its parallel output after the last bit.
- Drives the serial link that feeds the LED/serial-capture path; BUSY and DONE give the control logic a simple load handshake.

Parameters:
- WIDTH, 16, number of data bits per frame; legal range 2..32.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- CLR_N  in  1  asynchronous, active-low reset.
- LOAD  in  1  request to transmit DIN; accepted only while BUSY=0.
- DIN  in  WIDTH  parallel word to transmit; sampled on the accepting edge only.
- SOUT  out  1  serial data bit, LSB first; driven from the shift register bit 0, no combinational path from inputs.
- SVALID  out  1  high while SOUT carries a frame bit.
- BUSY  out  1  high while a frame is in flight; LOAD is ignored while high.
- DONE  out  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- Interface: one clock CLK; reset CLR_N is asynchronous and active-low.
- Reset (CLR_N=0, takes effect immediately, independent of CLK):
  - SOUT=0, SVALID=0, BUSY=0, DONE=0.
  - Shift register and bit counter = 0; state = IDLE.
- States: IDLE, SHIFT, DONE; all are registered.
- IDLE:
  - SVALID=0, BUSY=0, DONE=0, SOUT=0.
  - LOAD=1 at edge k: shreg<=DIN, cnt<=0, state<=SHIFT.
- SHIFT:
  - BUSY=1, SVALID=1, SOUT=shreg[0].
  - Each edge: shreg<=shreg>>1 with MSB filled 0, cnt<=cnt+1.
  - At the edge where cnt=WIDTH-1: state<=DONE.
  - Result: cycles k+1..k+WIDTH carry DIN[0]..DIN[WIDTH-1], exactly one bit per cycle.
- DONE:
  - Lasts exactly one cycle: DONE=1, BUSY=0, SVALID=0, SOUT=0.
  - Next edge: state<=IDLE, or direct capture if LOAD=1 (same action as in IDLE).
  - Minimum frame-to-frame gap is therefore one cycle.
- LOAD while BUSY=1: ignored, with no effect on the frame in progress; DIN changes mid-frame likewise have no effect.
- Counter width: $clog2(WIDTH+1) bits; never wraps within a frame.
- Reset asserted mid-frame: frame aborted, all outputs return to reset values at once, no DONE pulse. First LOAD after CLR_N rises starts a fresh frame.
- LOAD held high continuously: frames are sent back-to-back, WIDTH bits plus one DONE cycle each, and a new DIN is sampled in each DONE cycle.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - After DIN[WIDTH-1], one extra SHIFT cycle outputs even parity (XOR of the captured word) with SVALID=1.
  - Frame is WIDTH+1 valid cycles; DONE moves to cycle k+WIDTH+2.
  - Parity is computed at capture and stored in an extra register bit.
- Not defined: no parity bit; timing exactly as in Behaviour.

Test Plan:
- Reset, then LOAD=1 for one cycle with DIN=16'hA5C3 -> cycles k+1..k+16 SOUT = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 with SVALID=1 and BUSY=1; cycle k+17 DONE=1, BUSY=0. A model 16-bit serial-in register enabled by SVALID ends holding 16'hA5C3.
- LOAD pulsed again at cycles k+3 and k+10 with DIN=16'hFFFF -> ignored; the serial stream still equals 16'hA5C3 and only one DONE pulse occurs.
- LOAD held high with DIN=16'h0001, then 16'h8000 -> two frames with a one-cycle DONE gap; first frame SOUT high only on its first bit, second frame high only on its 16th bit.
- CLR_N driven low at frame bit 7 of DIN=16'hFFFF -> SOUT, SVALID, BUSY drop to 0 without waiting for CLK, and no DONE. After release, LOAD with DIN=16'h1234 yields a clean 16-bit frame of 16'h1234.
- With PISO_TX_PARITY_EN and DIN=16'h0007 -> 17 valid bits, 17th = 1. With DIN=16'h0003 -> 17th = 0. DONE occurs at k+18 in both cases.
- Idle for 50 cycles with LOAD=0 -> SOUT, SVALID, BUSY and DONE all remain 0.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: a captured word goes out LSB first, one bit per clock.
// Defining PISO_TX_PARITY_EN appends one even-parity bit to each frame.
module piso_tx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             SOUT,
  output logic             SVALID,
  output logic             BUSY,
  output logic             DONE
);

`ifdef PISO_TX_PARITY_EN
  localparam int unsigned SW = WIDTH + 1;
`else
  localparam int unsigned SW = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(SW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_shreg;
  logic [CW-1:0] r_cnt;
  logic          r_svalid;
  logic          r_done;
  logic [SW-1:0] w_load_word;

`ifdef PISO_TX_PARITY_EN
  // Parity is folded into the top shift-register bit so it leaves right after DIN[WIDTH-1].
  assign w_load_word = {^DIN, DIN};
`else
  assign w_load_word = DIN;
`endif

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_svalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (LOAD) begin
            r_shreg  <= w_load_word;
            r_cnt    <= '0;
            r_svalid <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_shreg <= {1'b0, r_shreg[SW-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_svalid <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_svalid <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  // The register is all zeros once a frame has fully shifted out, so bit 0 alone drives SOUT.
  assign SOUT   = r_shreg[0];
  assign SVALID = r_svalid;
  assign BUSY   = r_svalid;
  assign DONE   = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Directed, table-driven bench for piso_tx; parity cases run when PISO_TX_PARITY_EN is defined.
module tb_piso_tx;

  localparam int WIDTH = 16;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic              CLK;
  logic              CLR_N;
  logic              LOAD;
  logic [WIDTH-1:0]  DIN;
  logic              SOUT;
  logic              SVALID;
  logic              BUSY;
  logic              DONE;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    logic        load;
    logic [15:0] din;
    logic [3:0]  exp;   // {SOUT, SVALID, BUSY, DONE}
  } vec_t;

  vec_t        tbl [FL+2];
  logic [FL-1:0] model;
  int          ndone;

  piso_tx #(.WIDTH(WIDTH)) dut (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .LOAD  (LOAD),
    .DIN   (DIN),
    .SOUT  (SOUT),
    .SVALID(SVALID),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [15:0] w, input int i);
    if (i < WIDTH) return w[i];
    return ^w;
  endfunction

  function automatic logic [3:0] outs();
    return {SOUT, SVALID, BUSY, DONE};
  endfunction

  // Loads w, checks every frame bit, the DONE cycle, the recovered word, and the return to idle.
  task automatic run_frame(input logic [15:0] w, input string tag);
    LOAD = 1'b1;
    DIN  = w;
    tick();
    LOAD = 1'b0;
    DIN  = ~w;
    model = '0;
    for (int i = 0; i < FL; i++) begin
      chk({tag, "_bit"}, {28'd0, outs()}, {28'd0, fbit(w, i), 3'b110});
      if (SVALID) model = {SOUT, model[FL-1:1]};
      tick();
    end
    chk({tag, "_done"}, {28'd0, outs()}, 32'h1);
    chk({tag, "_word"}, {16'd0, model[WIDTH-1:0]}, {16'd0, w});
    tick();
    chk({tag, "_idle"}, {28'd0, outs()}, 32'h0);
  endtask

  initial begin
    CLR_N = 1'b0;
    LOAD  = 1'b0;
    DIN   = '0;
    #1;
    chk("reset_outs", {28'd0, outs()}, 32'h0);
    tick();
    tick();
    CLR_N = 1'b1;
    tick();
    chk("post_reset_idle", {28'd0, outs()}, 32'h0);

    // Frame of A5C3 with ignored LOAD pulses (DIN=FFFF) mid-frame.
    for (int j = 0; j < FL + 2; j++) begin
      tbl[j].load = 1'b0;
      tbl[j].din  = 16'hA5C3;
      tbl[j].exp  = 4'b0000;
      if (j == 0) tbl[j].load = 1'b1;
      if (j == 3 || j == 10) begin
        tbl[j].load = 1'b1;
        tbl[j].din  = 16'hFFFF;
      end
      if (j < FL)  tbl[j].exp = {fbit(16'hA5C3, j), 3'b110};
      if (j == FL) tbl[j].exp = 4'b0001;
    end
    model = '0;
    ndone = 0;
    for (int j = 0; j < FL + 2; j++) begin
      LOAD = tbl[j].load;
      DIN  = tbl[j].din;
      tick();
      chk("tbl_vec", {28'd0, outs()}, {28'd0, tbl[j].exp});
      if (SVALID) model = {SOUT, model[FL-1:1]};
      if (DONE) ndone++;
    end
    LOAD = 1'b0;
    chk("tbl_word", {16'd0, model[WIDTH-1:0]}, 32'h0000A5C3);
    chk("tbl_ndone", ndone, 1);

    // LOAD held high: back-to-back frames with a one-cycle DONE gap.
    LOAD = 1'b1;
    DIN  = 16'h0001;
    tick();
    DIN  = 16'h8000;
    for (int i = 0; i < FL; i++) begin
      chk("b2b_f1_bit", {28'd0, outs()}, {28'd0, fbit(16'h0001, i), 3'b110});
      tick();
    end
    chk("b2b_gap_done", {28'd0, outs()}, 32'h1);
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < FL; i++) begin
      chk("b2b_f2_bit", {28'd0, outs()}, {28'd0, fbit(16'h8000, i), 3'b110});
      tick();
    end
    chk("b2b_f2_done", {28'd0, outs()}, 32'h1);
    tick();
    chk("b2b_idle", {28'd0, outs()}, 32'h0);

    // Asynchronous reset at frame bit 7 of FFFF.
    LOAD = 1'b1;
    DIN  = 16'hFFFF;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("rst_bit7", {28'd0, outs()}, 32'hE);
    #2;
    CLR_N = 1'b0;
    #1;
    chk("rst_async", {28'd0, outs()}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold", {28'd0, outs()}, 32'h0);
    end
    CLR_N = 1'b1;
    tick();
    chk("rst_release", {28'd0, outs()}, 32'h0);
    run_frame(16'h1234, "after_rst");

`ifdef PISO_TX_PARITY_EN
    run_frame(16'h0007, "par7");
    run_frame(16'h0003, "par3");
`endif

    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle50", {28'd0, outs()}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
